// File: rtl/pu_mult_stim_driver.sv
// -----------------------------------------------------------------------------
// pu_mult_stim_driver
//
// Scripted stimulus sequencer for the pu_mult processing unit in the board-level
// play harness. Each iteration n writes operand A = n+1 (flagged invalid on every
// 2^INV_PERIOD_LOG2-th iteration), then operand B = n+2. It then waits for the
// multiplier latency and pulses output enable. The returned result is captured
// and compared against a locally computed truncated product and the expected
// invalid flag. Any mismatch latches a sticky fail flag that drives the LEDs.
//
// Ports
//   clk, RST      clock and synchronous active-high reset
//   run           level: keep iterating (1) or stop after the current iteration (0)
//   fast          1 = one-cycle pause between iterations, sampled on entry to PAUSE
//   signal_wr     pu_mult write strobe
//   signal_sel    pu_mult operand select (0 = A, 1 = B)
//   data_in       pu_mult operand data
//   attr_in       pu_mult operand attribute
//   signal_oe     pu_mult output enable
//   data_out      pu_mult result data
//   attr_out      pu_mult result attribute
//   busy          high in any state other than IDLE
//   iter          completed-iteration count, wraps at 2^16
//   fail          sticky mismatch flag, cleared only by RST
//   led           {fail, busy, iter[5:0]}
// -----------------------------------------------------------------------------

// Protocol checker: bus-level invariants of the strobes this block emits.
module pu_mult_stim_driver_chk #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4
) (
    input logic                  clk,
    input logic                  RST,
    input logic                  signal_wr,
    input logic                  signal_oe,
    input logic [DATA_WIDTH-1:0] data_in,
    input logic [ATTR_WIDTH-1:0] attr_in,
    input logic [DATA_WIDTH-1:0] data_out,
    input logic [ATTR_WIDTH-1:0] attr_out
);

    // Write and output enable must never overlap on the pu_mult bus.
    a_strobe_excl: assert property (@(posedge clk) disable iff (RST)
        !(signal_wr && signal_oe));

    // The operand bus is parked at zero whenever no write is in progress.
    a_quiet_bus: assert property (@(posedge clk) disable iff (RST)
        !signal_wr |-> ((data_in == '0) && (attr_in == '0)));

    // The result being captured must be fully driven.
    a_result_known: assert property (@(posedge clk) disable iff (RST)
        signal_oe |-> !$isunknown({data_out, attr_out}));

endmodule

module pu_mult_stim_driver #(
    parameter int DATA_WIDTH      = 32,
    parameter int ATTR_WIDTH      = 4,
    parameter int INVALID         = 1,
    parameter int MULT_LATENCY    = 2,
    parameter int PAUSE_WIDTH     = 24,
    parameter int INV_PERIOD_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  run,
    input  logic                  fast,
    output logic                  signal_wr,
    output logic                  signal_sel,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [ATTR_WIDTH-1:0] attr_in,
    output logic                  signal_oe,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  busy,
    output logic [15:0]           iter,
    output logic                  fail,
    output logic [7:0]            led
);

    // WAIT holds MULT_LATENCY-1 cycles; the counter is loaded with the number
    // of cycles remaining after the first WAIT cycle.
    localparam int LAT_W = (MULT_LATENCY > 2) ? $clog2(MULT_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT =
        LAT_W'((MULT_LATENCY > 1) ? (MULT_LATENCY - 2) : 0);

    // Slow pause is 2^PAUSE_WIDTH-1 cycles: load all-ones minus one, since
    // the first PAUSE cycle is spent before the counter is examined.
    localparam logic [PAUSE_WIDTH-1:0] PAUSE_INIT = {{(PAUSE_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_A  = 3'd1,
        ST_WR_B  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4,
        ST_CHECK = 3'd5,
        ST_PAUSE = 3'd6
    } state_t;

    state_t                  state_r;
    logic                    wr_r;
    logic                    sel_r;
    logic                    oe_r;
    logic [DATA_WIDTH-1:0]   data_in_r;
    logic [ATTR_WIDTH-1:0]   attr_in_r;
    logic                    busy_r;
    logic [15:0]             iter_r;
    logic                    fail_r;
    logic [LAT_W-1:0]        lat_cnt_r;
    logic [PAUSE_WIDTH-1:0]  pause_cnt_r;
    logic [DATA_WIDTH-1:0]   cap_data_r;
    logic                    cap_inv_r;

    logic [DATA_WIDTH-1:0]   op_a_s;
    logic [DATA_WIDTH-1:0]   op_b_s;
    logic                    inv_a_s;
    logic [ATTR_WIDTH-1:0]   attr_a_s;
    logic [DATA_WIDTH-1:0]   exp_data_s;
    logic                    exp_inv_s;
    logic                    mismatch_s;

    // Attribute word carrying only the invalid flag.
    function automatic logic [ATTR_WIDTH-1:0] make_attr(input logic inv_flag);
        logic [ATTR_WIDTH-1:0] a;
        a          = '0;
        a[INVALID] = inv_flag;
        return a;
    endfunction

    // Truncated product of two operands, formed at double width first.
    function automatic logic [DATA_WIDTH-1:0] trunc_mul(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return DATA_WIDTH'({{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b});
    endfunction

    // Operands and expectations for the iteration in flight. iter_r still
    // holds n until CHECK increments it, so everything derives from iter_r.
    always_comb begin
        op_a_s     = DATA_WIDTH'(iter_r) + DATA_WIDTH'(1);
        op_b_s     = DATA_WIDTH'(iter_r) + DATA_WIDTH'(2);
        inv_a_s    = (iter_r[INV_PERIOD_LOG2-1:0] == {INV_PERIOD_LOG2{1'b1}});
        attr_a_s   = make_attr(inv_a_s);
        exp_data_s = trunc_mul(op_a_s, op_b_s);
        // B is never flagged invalid, so the result flag follows A alone.
        exp_inv_s  = inv_a_s | 1'b0;
        if ((cap_data_r != exp_data_s) || (cap_inv_r != exp_inv_s)) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Sequencer FSM; every output is registered and set on the transition
    // into the state that owns it, so strobes line up with their state.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            wr_r        <= 1'b0;
            sel_r       <= 1'b0;
            oe_r        <= 1'b0;
            data_in_r   <= '0;
            attr_in_r   <= '0;
            busy_r      <= 1'b0;
            iter_r      <= 16'd0;
            fail_r      <= 1'b0;
            lat_cnt_r   <= '0;
            pause_cnt_r <= '0;
            cap_data_r  <= '0;
            cap_inv_r   <= 1'b0;
        end else begin
            // Bus parked unless a transition below drives it.
            wr_r      <= 1'b0;
            sel_r     <= 1'b0;
            oe_r      <= 1'b0;
            data_in_r <= '0;
            attr_in_r <= '0;
            busy_r    <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_r   <= ST_WR_A;
                        wr_r      <= 1'b1;
                        data_in_r <= op_a_s;
                        attr_in_r <= attr_a_s;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_WR_A: begin
                    state_r   <= ST_WR_B;
                    wr_r      <= 1'b1;
                    sel_r     <= 1'b1;
                    data_in_r <= op_b_s;
                end
                ST_WR_B: begin
                    if (MULT_LATENCY > 1) begin
                        state_r   <= ST_WAIT;
                        lat_cnt_r <= LAT_INIT;
                    end else begin
                        state_r <= ST_READ;
                        oe_r    <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_r == '0) begin
                        state_r <= ST_READ;
                        oe_r    <= 1'b1;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                end
                ST_READ: begin
                    // Result is valid while oe is high; capture it now.
                    cap_data_r <= data_out;
                    cap_inv_r  <= attr_out[INVALID];
                    state_r    <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        fail_r <= 1'b1;
                    end else begin
                        fail_r <= fail_r;
                    end
                    iter_r  <= iter_r + 16'd1;
                    state_r <= ST_PAUSE;
                    if (fast) begin
                        pause_cnt_r <= '0;
                    end else begin
                        pause_cnt_r <= PAUSE_INIT;
                    end
                end
                ST_PAUSE: begin
                    if (pause_cnt_r == '0) begin
                        if (run) begin
                            state_r   <= ST_WR_A;
                            wr_r      <= 1'b1;
                            data_in_r <= op_a_s;
                            attr_in_r <= attr_a_s;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        pause_cnt_r <= pause_cnt_r - PAUSE_WIDTH'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign signal_wr  = wr_r;
    assign signal_sel = sel_r;
    assign signal_oe  = oe_r;
    assign data_in    = data_in_r;
    assign attr_in    = attr_in_r;
    assign busy       = busy_r;
    assign iter       = iter_r;
    assign fail       = fail_r;
    assign led        = {fail_r, busy_r, iter_r[5:0]};

    pu_mult_stim_driver_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .ATTR_WIDTH (ATTR_WIDTH)
    ) u_chk (
        .clk       (clk),
        .RST       (RST),
        .signal_wr (wr_r),
        .signal_oe (oe_r),
        .data_in   (data_in_r),
        .attr_in   (attr_in_r),
        .data_out  (data_out),
        .attr_out  (attr_out)
    );

endmodule

// File: tb/tb_pu_mult_stim_driver.sv
// Bench for pu_mult_stim_driver: a latency-2 multiplier model answers the
// driver's strobes (optionally corrupting chosen results), a reference model
// predicts each iteration, and a monitor compares what the driver emits.
module tb_pu_mult_stim_driver;

    logic        clk = 1'b0;
    logic        RST;
    logic        run;
    logic        fast;
    logic        signal_wr;
    logic        signal_sel;
    logic [31:0] data_in;
    logic [3:0]  attr_in;
    logic        signal_oe;
    logic [31:0] data_out = 32'd0;
    logic [3:0]  attr_out = 4'd0;
    logic        busy;
    logic [15:0] iter;
    logic        fail;
    logic [7:0]  led;

    int n_checks = 0;
    int n_pass   = 0;

    // Results whose operand A equals these values get corrupted (0 = none).
    logic [31:0] corrupt_data_a = 32'd0;
    logic [31:0] corrupt_attr_a = 32'd0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        inv_a;
        logic        aborted;
        logic        exp_fail;
        logic [15:0] exp_iter;
    } rec_t;

    rec_t        exp_q[$];
    logic [15:0] ref_n    = 16'd0;
    logic        ref_fail = 1'b0;

    pu_mult_stim_driver dut (
        .clk        (clk),
        .RST        (RST),
        .run        (run),
        .fast       (fast),
        .signal_wr  (signal_wr),
        .signal_sel (signal_sel),
        .data_in    (data_in),
        .attr_in    (attr_in),
        .signal_oe  (signal_oe),
        .data_out   (data_out),
        .attr_out   (attr_out),
        .busy       (busy),
        .iter       (iter),
        .fail       (fail),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Multiplier model: latch A, produce the result the cycle after B.
    logic [31:0] ma_r     = 32'd0;
    logic        ma_inv_r = 1'b0;
    always @(posedge clk) begin
        if (signal_wr && !signal_sel) begin
            ma_r     <= data_in;
            ma_inv_r <= attr_in[1];
        end
        if (signal_wr && signal_sel) begin
            data_out <= ma_r * data_in + ((ma_r == corrupt_data_a) ? 32'd1 : 32'd0);
            attr_out <= {2'b00, (ma_inv_r | attr_in[1]) & (ma_r != corrupt_attr_a), 1'b0};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: predict one iteration from n and the corruption plan.
    task automatic push_rec(input bit aborted);
        rec_t r;
        logic bad;
        r.a     = 32'(ref_n) + 32'd1;
        r.b     = 32'(ref_n) + 32'd2;
        r.inv_a = (ref_n % 16'd16) == 16'd15;
        bad     = (r.a == corrupt_data_a) || ((r.a == corrupt_attr_a) && r.inv_a);
        if (!aborted) begin
            ref_fail = ref_fail | bad;
            ref_n    = ref_n + 16'd1;
        end
        r.aborted  = aborted;
        r.exp_fail = ref_fail;
        r.exp_iter = ref_n;
        exp_q.push_back(r);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        RST      = 1'b0;
        ref_n    = 16'd0;
        ref_fail = 1'b0;
        exp_q.delete();
    endtask

    // Run k iterations back to back; optionally abort the last one in WAIT.
    task automatic run_iters(input int k, input bit abort_last);
        int   cyc, seen, last;
        logic oe_seen;
        for (int i = 0; i < k; i++) push_rec(abort_last && (i == k - 1));
        run  = 1'b1;
        cyc  = 0;
        seen = 0;
        last = 0;
        while (seen < k) begin
            @(negedge clk);
            cyc++;
            if (signal_wr && !signal_sel) begin
                if (seen > 0) chk("iter_spacing", 64'(cyc - last), 64'd6);
                last = cyc;
                seen++;
                if (seen == k) run = 1'b0;
            end else if (cyc > 12 * k + 12) begin
                n_checks++;
                $display("FAIL wr_a_timeout: saw %0d WR_A, required %0d", seen, k);
                run = 1'b0;
                exp_q.delete();
                return;
            end
        end
        if (abort_last) begin
            @(negedge clk);
            @(negedge clk);
            chk("abort_in_wait", {signal_wr, signal_oe, busy}, 3'b001);
            RST = 1'b1;
            @(negedge clk);
            chk("abort_idle", {busy, signal_wr, signal_oe}, 3'b000);
            chk("abort_iter", iter, 16'd0);
            chk("abort_fail", fail, 1'b0);
            RST      = 1'b0;
            ref_n    = 16'd0;
            ref_fail = 1'b0;
            oe_seen  = 1'b0;
            repeat (10) begin
                @(negedge clk);
                oe_seen = oe_seen | signal_oe;
            end
            chk("abort_no_oe", oe_seen, 1'b0);
        end else begin
            for (int i = 0; i < 40 && busy; i++) @(negedge clk);
            chk("burst_returns_idle", busy, 1'b0);
        end
    endtask

    // Monitor: pop the expected iteration on each A write and follow it.
    initial begin : monitor
        rec_t       r;
        int         lat;
        logic       wr_seen;
        logic [3:0] ea;
        forever begin
            @(negedge clk);
            if (signal_oe) begin
                n_checks++;
                $display("FAIL stray_oe: signal_oe=1 outside an expected iteration, required 0");
            end else if (signal_wr && !signal_sel) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_wr_a: data_in=0x%0h with no iteration expected", data_in);
                end else begin
                    r     = exp_q.pop_front();
                    ea    = 4'b0000;
                    ea[1] = r.inv_a;
                    chk("wr_a_data", data_in, r.a);
                    chk("wr_a_attr", attr_in, ea);
                    @(negedge clk);
                    chk("wr_b_strobe", {signal_wr, signal_sel}, 2'b11);
                    chk("wr_b_data", data_in, r.b);
                    chk("wr_b_attr", attr_in, 4'd0);
                    if (!r.aborted) begin
                        lat     = 0;
                        wr_seen = 1'b0;
                        do begin
                            @(negedge clk);
                            lat++;
                            wr_seen = wr_seen | signal_wr | (data_in != 32'd0);
                        end while (!signal_oe && lat < 10);
                        chk("oe_latency", 64'(lat), 64'd2);
                        chk("wait_bus_quiet", wr_seen, 1'b0);
                        @(negedge clk);
                        chk("oe_single_pulse", signal_oe, 1'b0);
                        @(negedge clk);
                        chk("iter_after_check", iter, r.exp_iter);
                        chk("fail_after_check", fail, r.exp_fail);
                        chk("led_after_check", led, {r.exp_fail, 1'b1, r.exp_iter[5:0]});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k, gap;
        RST  = 1'b1;
        run  = 1'b0;
        fast = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {signal_wr, signal_sel, signal_oe}, 3'b000);
        chk("rst_busy_iter_fail", {busy, fail, iter}, 18'd0);
        RST = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_strobes", {signal_wr, signal_sel, signal_oe}, 3'b000);
        chk("idle_data_in", data_in, 32'd0);
        chk("idle_attr_in", attr_in, 4'd0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_iter", iter, 16'd0);
        chk("idle_led", led, 8'h00);

        // Clean run through the first invalid-flagged iteration (n=15).
        run_iters(16, 1'b0);

        // Result flag dropped on n=15 latches fail; good iterations keep it.
        do_reset();
        corrupt_attr_a = 32'd16;
        run_iters(16, 1'b0);
        run_iters(2, 1'b0);
        corrupt_attr_a = 32'd0;

        // Corrupt n=3 (21 instead of 20), then abort n=5 in WAIT.
        do_reset();
        corrupt_data_a = 32'd4;
        run_iters(4, 1'b0);
        run_iters(2, 1'b1);
        corrupt_data_a = 32'd0;

        // Iteration counter wrap from 16'hFFFF.
        do_reset();
        force dut.iter_r = 16'hFFFF;
        @(negedge clk);
        release dut.iter_r;
        @(negedge clk);
        chk("iter_preset", iter, 16'hFFFF);
        ref_n = 16'hFFFF;
        run_iters(2, 1'b0);

        // Random bursts with random gaps and occasional corruption.
        do_reset();
        for (int b = 0; b < 6; b++) begin
            k = int'($urandom_range(1, 3));
            gap = int'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0)
                corrupt_data_a = 32'(ref_n) + 32'd1 + 32'($urandom_range(0, k - 1));
            else
                corrupt_data_a = 32'd0;
            repeat (gap) @(negedge clk);
            run_iters(k, 1'b0);
        end
        corrupt_data_a = 32'd0;

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pu_mult_stim_driver.md
Name: pu_mult_stim_driver

Overview:
Self-checking stimulus sequencer that sits directly upstream of the pu_mult processing unit in the board-level play harness, replacing the free-running counter. It scripts the control strobes of pu_mult: write operand A, write operand B, wait, output enable. It captures the result on the output-enable cycle and compares it against a locally computed product and expected attribute. Pass/fail status is exported for the LEDs.

Parameters:
DATA_WIDTH, 32, width of operands and result.
ATTR_WIDTH, 4, width of attribute bus.
INVALID, 1, index of the invalid flag bit in attr.
MULT_LATENCY, 2, cycles from the B-write cycle to the cycle in which signal_oe is asserted.
PAUSE_WIDTH, 24, width of inter-iteration pause counter (pause = 2^PAUSE_WIDTH-1 cycles when fast=0).
INV_PERIOD_LOG2, 4, every 2^INV_PERIOD_LOG2-th iteration marks operand A invalid.

Ports:
clk  in  1  clock
RST  in  1  synchronous, active-high reset
run  in  1  level; 1 = iterate continuously, 0 = finish current iteration then idle
fast  in  1  1 = pause of 1 cycle instead of the full PAUSE_WIDTH count
signal_wr  out  1  to pu_mult write strobe
signal_sel  out  1  to pu_mult operand select (0 = A, 1 = B)
data_in  out  DATA_WIDTH  to pu_mult operand data
attr_in  out  ATTR_WIDTH  to pu_mult operand attribute
signal_oe  out  1  to pu_mult output enable
data_out  in  DATA_WIDTH  from pu_mult result
attr_out  in  ATTR_WIDTH  from pu_mult result attribute
busy  out  1  high in any state other than IDLE
iter  out  16  completed-iteration count
fail  out  1  sticky mismatch flag
led  out  8  {fail, busy, iter[5:0]}

Behaviour:
- Reset is synchronous, active-high, on clk. RST=1 forces IDLE, all strobes 0, data_in=0, attr_in=0, iter=0, fail=0, and pause/latency counters to 0. RST takes priority over every other event, including mid-iteration; no strobe is asserted in the cycle after RST deasserts.
- Operands for iteration n:
  - A = n+1 and B = n+2, zero-extended to DATA_WIDTH.
  - expected_data = (A*B) mod 2^DATA_WIDTH.
- Attributes:
  - attr_in = 0 for B.
  - attr_in for A has only bit INVALID set when n[INV_PERIOD_LOG2-1:0] == all-ones; otherwise 0.
  - expected_attr[INVALID] = OR of both operand INVALID bits. Only bit INVALID is checked.
- FSM (one state per cycle unless noted):
  - IDLE: if run=1, go to WR_A.
  - WR_A: signal_wr=1, sel=0, data_in=A, attr_in=attrA. Go to WR_B.
  - WR_B: signal_wr=1, sel=1, data_in=B, attr_in=0. Go to WAIT.
  - WAIT: count MULT_LATENCY-1 cycles (0 cycles if MULT_LATENCY=1). Go to READ.
  - READ: signal_oe=1. Register data_out and attr_out at the end of this cycle. Go to CHECK.
  - CHECK:
    - If the captured data != expected_data, or the captured attr[INVALID] != expected_attr[INVALID], set fail=1. fail stays set until RST.
    - iter += 1, wrapping at 2^16 to 0; operands wrap identically.
    - Go to PAUSE.
  - PAUSE: count 2^PAUSE_WIDTH-1 cycles, or 1 cycle if fast=1; fast is sampled on entry to PAUSE. Then go to WR_A if run=1, else IDLE.
- Strobe exclusivity: signal_wr and signal_oe are never high in the same cycle. Outside WR_A/WR_B, data_in and attr_in hold 0.
- Iteration length with fast=1 and run held high: 4+MULT_LATENCY cycles from WR_A to the next WR_A.
- run deasserted mid-iteration does not abort; the iteration completes including CHECK and PAUSE.
- Multiplication: the full product is computed at full width and truncated; no saturation.

Test Plan:
- RST=1 for 3 cycles, then run=0 → IDLE held, all outputs 0, led=8'h00.
- run=1, fast=1, ideal multiplier model with latency 2:
  - iter 0: WR_A with data_in=1, WR_B with data_in=2; oe asserted 2 cycles after WR_B; result 2; fail=0.
  - iter increments every 6 cycles.
- Iteration 15 (A=16, B=17): attr_in[1]=1 on WR_A; model returns 272 with attr_out[1]=1 → fail=0. Model returning attr_out=0 instead → fail=1 after CHECK, and fail stays 1.
- Model corrupts the result of iter 3 (returns 21 instead of 20) → fail=1 in the cycle after CHECK; later good iterations leave fail=1.
- Assert RST during WAIT of iter 5 → next cycle is IDLE, iter=0, fail=0, no oe pulse is emitted for the aborted iteration.
- Force iter to 16'hFFFF via a long run (or a bench force) → the next CHECK wraps iter to 0; the next operands are A=1, B=2.
